// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array result path.
package systolic_pkg;

    // Drain controller states.
    typedef enum logic {
        IDLE,
        STREAM
    } drain_state_e;

    // Widest accumulator value the saturation helper accepts.
    localparam int SAT_MAX_W = 64;

    // Default PE accumulator width: full product plus growth for N additions.
    function automatic int default_dw_out(input int dw_in, input int n);
        return 2 * dw_in + $clog2(n);
    endfunction

    // Clamp a sign-extended value to the signed range of 'width' bits.
    // The caller takes the low 'width' bits of the result.
    function automatic logic signed [SAT_MAX_W-1:0] sat_narrow(
        input logic signed [SAT_MAX_W-1:0] value,
        input int                          width
    );
        logic signed [SAT_MAX_W-1:0] max_v;
        logic signed [SAT_MAX_W-1:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// Result stream from the drain to the sink: row-major elements over valid/ready.
interface systolic_result_drain_if
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = 4,
    parameter int RES_W      = default_dw_out(8, 4)
);
    localparam int RC_W = $clog2(ARRAY_SIZE);

    logic signed [RES_W-1:0] res_data_o;
    logic [RC_W-1:0]         res_row_o;
    logic [RC_W-1:0]         res_col_o;
    logic                    res_valid_o;
    logic                    res_ready_i;

    // The drain produces elements.
    modport master (
        output res_data_o, res_row_o, res_col_o, res_valid_o,
        input  res_ready_i
    );

    // The sink consumes elements.
    modport slave (
        input  res_data_o, res_row_o, res_col_o, res_valid_o,
        output res_ready_i
    );

endinterface

// File: rtl/res_sat.sv
// Narrows one accumulator value to the result width.
// Build option DRAIN_SAT_EN: signed saturation instead of two's-complement
// truncation when RES_W < DW_OUT. Equal widths pass through unchanged.
module res_sat
    import systolic_pkg::*;
#(
    parameter int DW_OUT = 18,
    parameter int RES_W  = 18
) (
    input  logic signed [DW_OUT-1:0] din,
    output logic signed [RES_W-1:0]  dout
);

    generate
        if (RES_W < DW_OUT) begin : g_narrow
`ifdef DRAIN_SAT_EN
            logic signed [SAT_MAX_W-1:0] wide;
            // Sign-extend, clamp to the target range, keep the low bits.
            assign wide = {{(SAT_MAX_W - DW_OUT){din[DW_OUT-1]}}, din};
            assign dout = RES_W'(sat_narrow(wide, RES_W));
`else
            // Two's-complement truncation: keep the low RES_W bits.
            assign dout = RES_W'(din);
`endif
        end else begin : g_pass
            // Full width: value passes through untouched.
            assign dout = RES_W'(din);
        end
    endgenerate

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the PE accumulator grid on done_i, pulses a clear to the array,
// then streams the N*N results row-major over valid/ready.
// Build option DRAIN_SAT_EN selects saturating narrowing (see res_sat).
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = 4,
    parameter int DW_IN      = 8,
    parameter int DW_OUT     = default_dw_out(DW_IN, ARRAY_SIZE),
    parameter int RES_W      = DW_OUT
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        done_i,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*DW_OUT-1:0]     p_flat_i,
    output logic                                        acc_clr_o,
    output logic                                        busy_o,
    output logic                                        ovf_o,
    systolic_result_drain_if.master                     res
);

    localparam int NN    = ARRAY_SIZE * ARRAY_SIZE;
    localparam int IDX_W = $clog2(NN);
    localparam int RC_W  = $clog2(ARRAY_SIZE);

    localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(ARRAY_SIZE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    logic signed [DW_OUT-1:0] snap [NN];
    drain_state_e             state;
    logic [IDX_W-1:0]         idx;
    logic [RC_W-1:0]          row;
    logic [RC_W-1:0]          col;
    logic                     valid;
    logic                     busy;
    logic                     acc_clr;
    logic                     ovf;
    logic                     xfer;
    logic signed [RES_W-1:0]  narrow;

    assign xfer = valid && res.res_ready_i;

    // Capture the whole grid in one cycle when a tile completes while idle.
    // NOTE: the snapshot buffer has no reset; its contents are never read
    // before a capture, and leaving it out keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (state == IDLE && done_i) begin
            for (int i = 0; i < NN; i++) begin
                snap[i] <= p_flat_i[i*DW_OUT +: DW_OUT];
            end
        end
    end

    // Drain FSM: registered valid/busy/clear, row/col counters, sticky overflow.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            row     <= '0;
            col     <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            acc_clr <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            // A tile finishing while one is still held is dropped and flagged.
            if (done_i && state == STREAM) begin
                ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (done_i) begin
                        state   <= STREAM;
                        idx     <= '0;
                        row     <= '0;
                        col     <= '0;
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        acc_clr <= 1'b1;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                            idx   <= '0;
                            row   <= '0;
                            col   <= '0;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                            if (col == LAST_RC) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    res_sat #(
        .DW_OUT (DW_OUT),
        .RES_W  (RES_W)
    ) u_res_sat (
        .din  (snap[idx]),
        .dout (narrow)
    );

    // Data reads zero whenever no element is offered.
    assign res.res_data_o  = valid ? narrow : '0;
    assign res.res_row_o   = row;
    assign res.res_col_o   = col;
    assign res.res_valid_o = valid;
    assign acc_clr_o       = acc_clr;
    assign busy_o          = busy;
    assign ovf_o           = ovf;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: a full-width instance for the
// streaming behaviour and an RES_W=8 instance for the narrowing path.
module tb_systolic_result_drain;
    import systolic_pkg::*;

    localparam int N       = 4;
    localparam int NN      = N * N;
    localparam int DW_IN   = 8;
    localparam int DW_OUT  = default_dw_out(DW_IN, N);
    localparam int RES_W_N = 8;
    localparam int RC_W    = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                   done;
    logic [NN*DW_OUT-1:0]   p_flat;
    logic                   acc_clr, busy, ovf;
    logic                   done_n;
    logic [NN*DW_OUT-1:0]   p_flat_n;
    logic                   acc_clr_n, busy_n, ovf_n;

    systolic_result_drain_if #(.ARRAY_SIZE(N), .RES_W(DW_OUT))  rif ();
    systolic_result_drain_if #(.ARRAY_SIZE(N), .RES_W(RES_W_N)) rif_n ();

    systolic_result_drain #(
        .ARRAY_SIZE (N),
        .DW_IN      (DW_IN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .done_i    (done),
        .p_flat_i  (p_flat),
        .acc_clr_o (acc_clr),
        .busy_o    (busy),
        .ovf_o     (ovf),
        .res       (rif)
    );

    systolic_result_drain #(
        .ARRAY_SIZE (N),
        .DW_IN      (DW_IN),
        .RES_W      (RES_W_N)
    ) dut_n (
        .clk       (clk),
        .rst       (rst),
        .done_i    (done_n),
        .p_flat_i  (p_flat_n),
        .acc_clr_o (acc_clr_n),
        .busy_o    (busy_n),
        .ovf_o     (ovf_n),
        .res       (rif_n)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_q [NN];

    function automatic logic [NN*DW_OUT-1:0] with_pe(
        input logic [NN*DW_OUT-1:0] flat, input int i, input int value);
        logic [NN*DW_OUT-1:0] f;
        f = flat;
        f[i*DW_OUT +: DW_OUT] = DW_OUT'(value);
        return f;
    endfunction

    // Tile with PE(r,c) = 10*r + c.
    task automatic load_ramp();
        for (int i = 0; i < NN; i++) begin
            exp_q[i] = 10 * (i / N) + (i % N);
            p_flat   = with_pe(p_flat, i, exp_q[i]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({acc_clr, rif.res_valid_o, busy, ovf} !== 4'b0000 ||
            rif.res_data_o !== '0 || rif.res_row_o !== '0 || rif.res_col_o !== '0) begin
            tests_failed++;
            $display("FAIL reset: clr=%b v=%b busy=%b ovf=%b d=%0d r=%0d c=%0d, want all 0",
                     acc_clr, rif.res_valid_o, busy, ovf, rif.res_data_o,
                     rif.res_row_o, rif.res_col_o);
        end
        tests_run++;
        if ({acc_clr_n, rif_n.res_valid_o, busy_n, ovf_n} !== 4'b0000 ||
            rif_n.res_data_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_narrow: clr=%b v=%b busy=%b ovf=%b d=%0d, want all 0",
                     acc_clr_n, rif_n.res_valid_o, busy_n, ovf_n, rif_n.res_data_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        load_ramp();
        rif.res_ready_i = 1'b1;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        for (int k = 0; k < NN; k++) begin
            tests_run++;
            if (rif.res_valid_o !== 1'b1 || busy !== 1'b1 ||
                rif.res_data_o !== DW_OUT'(exp_q[k]) ||
                rif.res_row_o !== RC_W'(k / N) || rif.res_col_o !== RC_W'(k % N)) begin
                tests_failed++;
                $display("FAIL basic_elem%0d: v=%b busy=%b d=%0d r=%0d c=%0d, want v=1 busy=1 d=%0d r=%0d c=%0d",
                         k, rif.res_valid_o, busy, rif.res_data_o, rif.res_row_o,
                         rif.res_col_o, exp_q[k], k / N, k % N);
            end
            tests_run++;
            if (acc_clr !== (k == 0)) begin
                tests_failed++;
                $display("FAIL basic_clr%0d: acc_clr=%b, want %b", k, acc_clr, k == 0);
            end
            @(negedge clk);
        end
        tests_run++;
        if (busy !== 1'b0 || rif.res_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_end: busy=%b v=%b, want 0 0", busy, rif.res_valid_o);
        end
    endtask

    task automatic test_stall();
        int n;
        int cyc;
        load_ramp();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        n   = 0;
        cyc = 0;
        while (n < NN && cyc < 200) begin
            rif.res_ready_i = (cyc % 3 == 0);
            tests_run++;
            if (rif.res_valid_o !== 1'b1 || rif.res_data_o !== DW_OUT'(exp_q[n]) ||
                rif.res_row_o !== RC_W'(n / N) || rif.res_col_o !== RC_W'(n % N)) begin
                tests_failed++;
                $display("FAIL stall_cyc%0d: v=%b d=%0d r=%0d c=%0d, want v=1 d=%0d r=%0d c=%0d",
                         cyc, rif.res_valid_o, rif.res_data_o, rif.res_row_o,
                         rif.res_col_o, exp_q[n], n / N, n % N);
            end
            if (rif.res_ready_i) n++;
            @(negedge clk);
            cyc++;
        end
        rif.res_ready_i = 1'b1;
        tests_run++;
        if (n != NN || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_end: transferred=%0d busy=%b, want %0d 0", n, busy, NN);
        end
    endtask

    task automatic test_ovf();
        load_ramp();
        rif.res_ready_i = 1'b1;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        for (int k = 0; k < NN; k++) begin
            if (k == 5) begin
                for (int i = 0; i < NN; i++) p_flat = with_pe(p_flat, i, 100 + i);
            end
            done = (k == 5);
            tests_run++;
            if (rif.res_data_o !== DW_OUT'(exp_q[k]) || rif.res_valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL ovf_elem%0d: v=%b d=%0d, want v=1 d=%0d",
                         k, rif.res_valid_o, rif.res_data_o, exp_q[k]);
            end
            if (k > 0) begin
                tests_run++;
                if (acc_clr !== 1'b0 || ovf !== (k >= 6)) begin
                    tests_failed++;
                    $display("FAIL ovf_flags%0d: clr=%b ovf=%b, want clr=0 ovf=%b",
                             k, acc_clr, ovf, k >= 6);
                end
            end
            @(negedge clk);
        end
        done = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ovf !== 1'b1 || busy !== 1'b0 || acc_clr !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_sticky: ovf=%b busy=%b clr=%b, want 1 0 0", ovf, busy, acc_clr);
        end
        do_reset();
    endtask

    task automatic test_snapshot();
        for (int i = 0; i < NN; i++) begin
            exp_q[i] = -(1000 * i) - 3;
            p_flat   = with_pe(p_flat, i, exp_q[i]);
        end
        rif.res_ready_i = 1'b1;
        done = 1'b1;
        @(negedge clk);
        done   = 1'b0;
        p_flat = '1;
        for (int k = 0; k < NN; k++) begin
            tests_run++;
            if (rif.res_data_o !== DW_OUT'(exp_q[k]) || rif.res_valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL snap_elem%0d: v=%b d=%0d, want v=1 d=%0d",
                         k, rif.res_valid_o, rif.res_data_o, exp_q[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        load_ramp();
        rif.res_ready_i = 1'b1;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (NN - 1) @(negedge clk);
        // Final element on offer: a new tile arrives in the same cycle.
        tests_run++;
        if (rif.res_data_o !== DW_OUT'(exp_q[NN-1]) || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_last: d=%0d ovf=%b, want d=%0d ovf=0",
                     rif.res_data_o, ovf, exp_q[NN-1]);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        tests_run++;
        if ({busy, rif.res_valid_o, ovf, acc_clr} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL b2b_after: busy=%b v=%b ovf=%b clr=%b, want 0 0 1 0",
                     busy, rif.res_valid_o, ovf, acc_clr);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || acc_clr !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_nocapture: busy=%b clr=%b, want 0 0", busy, acc_clr);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        load_ramp();
        rif.res_ready_i = 1'b1;
        done = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            done = (k == 2);
            if (k == 7) rst = 1'b1;
            @(negedge clk);
        end
        done = 1'b0;
        rst  = 1'b0;
        tests_run++;
        if ({rif.res_valid_o, busy, ovf, acc_clr} !== 4'b0000 ||
            rif.res_data_o !== '0 || rif.res_row_o !== '0 || rif.res_col_o !== '0) begin
            tests_failed++;
            $display("FAIL rstmid: v=%b busy=%b ovf=%b clr=%b d=%0d r=%0d c=%0d, want all 0",
                     rif.res_valid_o, busy, ovf, acc_clr, rif.res_data_o,
                     rif.res_row_o, rif.res_col_o);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        tests_run++;
        if (rif.res_valid_o !== 1'b1 || acc_clr !== 1'b1 || rif.res_data_o !== DW_OUT'(exp_q[0]) ||
            rif.res_row_o !== '0 || rif.res_col_o !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_restart: v=%b clr=%b d=%0d r=%0d c=%0d, want 1 1 %0d 0 0",
                     rif.res_valid_o, acc_clr, rif.res_data_o, rif.res_row_o,
                     rif.res_col_o, exp_q[0]);
        end
        repeat (NN) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_drain: busy=%b ovf=%b, want 0 0", busy, ovf);
        end
    endtask

    task automatic test_width();
        int exp_n [NN];
        p_flat_n = '0;
        for (int i = 0; i < NN; i++) exp_n[i] = 0;
        p_flat_n = with_pe(p_flat_n, 0, 300);
        p_flat_n = with_pe(p_flat_n, 1, -300);
        p_flat_n = with_pe(p_flat_n, 2, -5);
        p_flat_n = with_pe(p_flat_n, 3, 127);
`ifdef DRAIN_SAT_EN
        exp_n[0] = 127;
        exp_n[1] = -128;
`else
        exp_n[0] = 44;
        exp_n[1] = -44;
`endif
        exp_n[2] = -5;
        exp_n[3] = 127;
        rif_n.res_ready_i = 1'b1;
        done_n = 1'b1;
        @(negedge clk);
        done_n = 1'b0;
        for (int k = 0; k < NN; k++) begin
            tests_run++;
            if (rif_n.res_valid_o !== 1'b1 || rif_n.res_data_o !== RES_W_N'(exp_n[k]) ||
                rif_n.res_row_o !== RC_W'(k / N) || rif_n.res_col_o !== RC_W'(k % N)) begin
                tests_failed++;
                $display("FAIL width_elem%0d: v=%b d=%0d r=%0d c=%0d, want v=1 d=%0d r=%0d c=%0d",
                         k, rif_n.res_valid_o, rif_n.res_data_o, rif_n.res_row_o,
                         rif_n.res_col_o, exp_n[k], k / N, k % N);
            end
            @(negedge clk);
        end
        tests_run++;
        if (busy_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL width_end: busy=%b, want 0", busy_n);
        end
    endtask

    initial begin
        rst               = 1'b1;
        done              = 1'b0;
        done_n            = 1'b0;
        p_flat            = '0;
        p_flat_n          = '0;
        rif.res_ready_i   = 1'b0;
        rif_n.res_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_ovf();
        test_snapshot();
        test_back_to_back();
        test_reset_mid();
        test_width();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
